vlogic_share_arbiter: RTL and testbench
=======================================

// Module: vlogic_share_arbiter
// PURPOSE
//   Shares one registered bitwise-logic unit (AND/OR/XOR/NOT, SIZE bits) among NREQ requesters.
//   Round-robin grant, valid/ready on each request port and on the single response port.
//   One operation in flight at a time. Sits between FM-radio control/DSP clients and the vector-logic datapath.
// PARAMETERS
//   NREQ   4   number of requesters, 2..8
//   SIZE   8   operand/result width in bits, 1..32
//   IDW    2   requester-ID width, must satisfy 2**IDW >= NREQ
// PORTS
//   clk        in   1          single system clock, rising edge
//   rst        in   1          synchronous reset, active-high
//   req_valid  in   NREQ       request i presents an operation
//   req_ready  out  NREQ       request i accepted this cycle (one-hot or zero)
//   req_op     in   2*NREQ     op for requester i at [2i+:2]: 0 AND, 1 OR, 2 XOR, 3 NOT(a)
//   req_a      in   SIZE*NREQ  operand a for requester i at [SIZE*i+:SIZE]
//   req_b      in   SIZE*NREQ  operand b for requester i, ignored for NOT
//   rsp_valid  out  1          result available
//   rsp_ready  in   1          consumer takes result
//   rsp_data   out  SIZE       result vector
//   rsp_id     out  IDW        index of requester that issued the result
//   busy       out  1          high in every state except IDLE
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
//   FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: req_ready is driven combinationally. It is one-hot on the first requester with
//     req_valid set, searching from rr_ptr upward and wrapping at NREQ.
//     On grant, capture op/a/b/id, set rr_ptr=(id+1)%NREQ and go to EXEC.
//     With no valid request, stay in IDLE.
//   EXEC (1 cycle): register rsp_data=f(op,a,b) and rsp_id=id, then go to RESP.
//   RESP: rsp_valid=1. rsp_data and rsp_id stay stable until rsp_ready.
//     On rsp_ready, go to IDLE; rsp_valid is 0 the next cycle.
//   req_ready=0 in EXEC and RESP. No request is accepted while a result is pending.
//   Latency: grant cycle T -> rsp_valid at T+2. Peak throughput is 1 op per 3 cycles.
//   rsp_ready held high constantly gives back-to-back grants every 3 cycles.
//   Requester dropping req_valid before grant: legal, nothing captured.
//     Requester changing operands while ungranted: the value present at grant is used.
//   Only one requester valid: it is granted every round, whatever rr_ptr is.
//   All NREQ valid continuously: grants rotate 0,1,..,NREQ-1,0. No starvation; wait <= NREQ-1 ops.
//   rst asserted in any state: the in-flight op is discarded, no response is emitted,
//     and all outputs return to reset values on the next edge.
//   rst has priority over every handshake in the same cycle.
// CONFIGURATION
//   VLOGIC_ARB_STATS_EN defined:
//     adds output  stat_ops  32  count of completed responses (RESP with rsp_ready).
//     The counter resets to 0 on rst and wraps modulo 2**32.
//     It adds 1 register stage only in the counter and does not change handshake timing.
//   VLOGIC_ARB_STATS_EN undefined: the stat_ops port and counter are absent.
//     Behaviour is otherwise identical.
// STRUCTURE
//   Package vlogic_pkg holds:
//     op localparams OP_AND=2'd0, OP_OR=2'd1, OP_XOR=2'd2, OP_NOT=2'd3;
//     state encoding ST_IDLE, ST_EXEC, ST_RESP (2 bits);
//     function vlogic_eval(op, a, b), shared with any other vector-logic users.
//   Sub-module vlogic_rr_arbiter(NREQ): inputs req, ptr; outputs one-hot gnt, gnt_id, any.
//     Purely combinational; the pointer register stays in the top.
//   The top holds the FSM, operand capture registers, result register and optional stats counter.
// TESTING
//   1 Reset: rst high 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, busy=0 throughout.
//   2 Single op: NREQ=4, SIZE=8, req 2 XOR a=8'hF0 b=8'h3C, rsp_ready=1
//       -> req_ready=4'b0100 at T; rsp_valid at T+2 with rsp_data=8'hCC, rsp_id=2.
//   3 Ops: req0 NOT a=8'hA5 -> 8'h5A; req1 AND 8'hF0,8'h3C -> 8'h30; req3 OR 8'h0F,8'h30 -> 8'h3F.
//   4 Fairness: all 4 valid continuously, rsp_ready=1 for 12 ops
//       -> rsp_id sequence 0,1,2,3,0,1,2,3,0,1,2,3; grants exactly 3 cycles apart.
//   5 Backpressure: rsp_ready=0 for 5 cycles in RESP
//       -> rsp_valid, rsp_data, rsp_id stable; req_ready=0; next grant 1 cycle after rsp_ready rises.
//   6 Reset mid-op: rst in EXEC -> no rsp_valid ever for that op; rr_ptr=0, so with all valid the next grant is req 0.
//       With VLOGIC_ARB_STATS_EN, stat_ops=0 after reset and equals 12 after scenario 4.

Source files
------------

// File: rtl/vlogic_pkg.sv
// Shared definitions for the vector-logic datapath: op codes, arbiter FSM encoding
// and the bitwise evaluation function used by every vector-logic client.
package vlogic_pkg;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Evaluated at full 32-bit width; callers truncate to their operand size.
    function automatic logic [31:0] vlogic_eval(input logic [1:0]  op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vlogic_rr_arbiter.sv
// Combinational round-robin picker: grants the first set request at or after ptr,
// wrapping at NREQ. The pointer register lives in the caller.
module vlogic_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    int unsigned idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vlogic_share_arbiter.sv
// Shares one registered AND/OR/XOR/NOT unit among NREQ requesters, one op in flight.
// Define VLOGIC_ARB_STATS_EN to add the 32-bit stat_ops completed-response counter.
module vlogic_share_arbiter
    import vlogic_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned SIZE = 8,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [SIZE*NREQ-1:0] req_a,
    input  logic [SIZE*NREQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [SIZE-1:0]      rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
`ifdef VLOGIC_ARB_STATS_EN
    ,
    output logic [31:0]          stat_ops
`endif
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]      op_q, op_d;
    logic [SIZE-1:0] a_q, a_d, b_q, b_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [SIZE-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            any;

    vlogic_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    // Gated by rst so nothing is offered while reset is held.
    assign req_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            op_d = req_op[2*i +: 2];
                            a_d  = req_a[SIZE*i +: SIZE];
                            b_d  = req_b[SIZE*i +: SIZE];
                        end
                    end
                    id_d = gnt_id;
                    if (32'(gnt_id) == NREQ - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt_id + IDW'(1);
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = SIZE'(vlogic_eval(op_q, 32'(a_q), 32'(b_q)));
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

`ifdef VLOGIC_ARB_STATS_EN
    logic [31:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (state_q == ST_RESP && rsp_ready) begin
            stat_d = stat_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_ops = stat_q;
`endif

endmodule

// File: tb/tb_vlogic_share_arbiter.sv
// Directed bench for vlogic_share_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_vlogic_share_arbiter;

    localparam int N = 4;
    localparam int S = 8;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [S*N-1:0] req_a;
    logic [S*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [S-1:0]   rsp_data;
    logic [W-1:0]   rsp_id;
    logic           busy;
`ifdef VLOGIC_ARB_STATS_EN
    logic [31:0]    stat_ops;
`endif

    int n_cmp = 0;
    int n_err = 0;

    vlogic_share_arbiter #(
        .NREQ (N),
        .SIZE (S),
        .IDW  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef VLOGIC_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [S-1:0] ref_eval(input logic [1:0] op, input logic [S-1:0] a,
                                              input logic [S-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic int find_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Reference model: m_age is cycles since the grant (-1 = no op in flight).
    bit          m_known = 0;
    int          m_age   = -1;
    int          m_ptr   = 0;
    logic [S-1:0] m_data;
    int          m_id;
    int unsigned m_ops   = 0;

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int w;
        exp_ready = '0;
        w = -1;
        if (m_known) begin
            check("rsp_valid", 32'(rsp_valid), 32'(m_age >= 2));
            check("busy", 32'(busy), 32'(m_age >= 1));
            if (m_age >= 2) begin
                check("rsp_data", 32'(rsp_data), 32'(m_data));
                check("rsp_id", 32'(rsp_id), 32'(m_id));
            end
`ifdef VLOGIC_ARB_STATS_EN
            check("stat_ops", stat_ops, m_ops);
`endif
        end
        if (!rst && m_known && m_age < 0) begin
            w = find_winner(req_valid, m_ptr);
            if (w >= 0) exp_ready = N'(1 << w);
        end
        if (rst || m_known) check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (rst) begin
            m_known = 1;
            m_age   = -1;
            m_ptr   = 0;
            m_ops   = 0;
        end else if (m_known) begin
            if (w >= 0) begin
                m_id   = w;
                m_data = ref_eval(req_op[2*w +: 2], req_a[S*w +: S], req_b[S*w +: S]);
                m_ptr  = (w + 1) % N;
                m_age  = 1;
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (m_age == 2 && rsp_ready) begin
                m_age = -1;
                m_ops++;
            end
        end
    end

    task automatic wait_grant(output logic [N-1:0] g);
        bit ok = 0;
        g = '0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1;
                g  = req_ready;
            end
        end
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input int id, input logic [1:0] op, input logic [S-1:0] a,
                         input logic [S-1:0] b, input logic [S-1:0] exp_data);
        logic [N-1:0] g;
        @(posedge clk); #1;
        req_valid            = N'(1 << id);
        req_op[2*id +: 2]    = op;
        req_a[S*id +: S]     = a;
        req_b[S*id +: S]     = b;
        wait_grant(g);
        check("op_grant", 32'(g), 32'(1 << id));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("op_exec_novalid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("op_rsp_valid", 32'(rsp_valid), 32'd1);
        check("op_rsp_data", 32'(rsp_data), 32'(exp_data));
        check("op_rsp_id", 32'(rsp_id), 32'(id));
    endtask

    task automatic set_all();
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2] = 2'(i);
            req_a[S*i +: S]  = S'(8'h3C + 8'h11 * i);
            req_b[S*i +: S]  = S'(8'hA5 ^ (8'h0F << i));
        end
        req_valid = '1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int          ids[$];
        int          gcyc[$];
        logic [N-1:0] g;
        logic [S-1:0] d0;
        logic [W-1:0] i0;
        rst       = 1'b1;
        req_valid = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset held with every requester valid.
        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
`ifdef VLOGIC_ARB_STATS_EN
        check("rst_stat_ops", stat_ops, 32'd0);
`endif
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;

        do_op(2, 2'd2, 8'hF0, 8'h3C, 8'hCC);
        do_op(0, 2'd3, 8'hA5, 8'h00, 8'h5A);
        do_op(1, 2'd0, 8'hF0, 8'h3C, 8'h30);
        do_op(3, 2'd1, 8'h0F, 8'h30, 8'h3F);

        // Fairness with all requesters valid and no backpressure.
        pulse_reset();
        set_all();
        for (int c = 0; c < 80 && ids.size() < 12; c++) begin
            @(negedge clk);
            if (req_ready != '0) gcyc.push_back(c);
            if (rsp_valid && rsp_ready) ids.push_back(int'(rsp_id));
        end
        @(posedge clk); #1;
        req_valid = '0;
        check("fair_count", 32'(ids.size()), 32'd12);
        for (int i = 0; i < 12 && i < ids.size(); i++) check("fair_id", 32'(ids[i]), 32'(i % 4));
        check("fair_grants", 32'(gcyc.size() >= 12), 32'd1);
        for (int i = 0; i + 1 < 12 && i + 1 < gcyc.size(); i++)
            check("fair_spacing", 32'(gcyc[i+1] - gcyc[i]), 32'd3);
        @(negedge clk);
`ifdef VLOGIC_ARB_STATS_EN
        check("stat_after_fair", stat_ops, 32'd12);
`endif

        // Backpressure while a response is pending.
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        set_all();
        wait_grant(g);
        check("bp_grant", 32'(g), 32'b0001);
        @(negedge clk);
        @(negedge clk);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_data", 32'(rsp_data), 32'(ref_eval(2'd0, 8'h3C, 8'hA5 ^ 8'h0F)));
        d0 = rsp_data;
        i0 = rsp_id;
        check("bp_rsp_id", 32'(i0), 32'd0);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data", 32'(rsp_data), 32'(d0));
            check("bp_hold_id", 32'(rsp_id), 32'(i0));
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Reset while an op is executing.
        do_op(2, 2'd1, 8'h81, 8'h18, 8'h99);
        @(posedge clk); #1;
        set_all();
        @(negedge clk);
        check("mid_pre_grant", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_exec_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_after_grant", 32'(req_ready), 32'b0001);
        check("mid_no_rsp", 32'(rsp_valid), 32'd0);
`ifdef VLOGIC_ARB_STATS_EN
        check("mid_stat_ops", stat_ops, 32'd0);
`endif
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
